sprite_compositor: RTL and testbench
====================================

SPRITE_COMPOSITOR -- requirements
Module: sprite_compositor

Interface
REQ-001 SHALL have parameter NUM_SPRITES, default 8: number of sprite slots (power of two, 2..16).
REQ-002 SHALL have parameter SPRITE_SIZE, default 16: sprite edge length in pixels (square, solid colour).
REQ-003 SHALL have parameter BG_COLOR, default 12'h000: RGB444 colour when no sprite covers the pixel.
REQ-004 SHALL have one clock and an asynchronous active-low reset: pixel_clk  in  1  pixel clock, 25 MHz; reset_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have vtg_ce  in  1  pixel enable; the pixel pipeline advances only on cycles where it is 1.
REQ-006 SHALL have next_pixel_x, next_pixel_y  in  10 each  coordinate of the upcoming pixel from the timing generator.
REQ-007 SHALL have next_video_on  in  1; hsync, vsync  in  1 each  timing-generator outputs.
REQ-008 SHALL have spr_wr_valid  in  1; spr_wr_ready  out  1; spr_wr_idx  in  log2(NUM_SPRITES); spr_wr_x, spr_wr_y  in  10 each; spr_wr_color  in  12; spr_wr_enable  in  1 (slot visible).
REQ-009 SHALL have commit_req  in  1 (pulse); commit_pending  out  1.
REQ-010 SHALL have rgb  out  12; de_out, hsync_out, vsync_out  out  1 each.

Function
REQ-011 SHALL hold two sprite tables: shadow (written by host) and active (used for rendering).
REQ-012 SHALL write shadow[spr_wr_idx] on a cycle with spr_wr_valid=1 and spr_wr_ready=1; other cycles leave the shadow table unchanged.
REQ-013 SHALL run FSM IDLE/PENDING/COPY on every pixel_clk, independent of vtg_ce.
REQ-014 SHALL drive spr_wr_ready=1 only in IDLE.
REQ-015 SHALL, in IDLE, go to PENDING on commit_req=1; a simultaneous accepted write SHALL complete before the commit.
REQ-016 SHALL ignore commit_req in PENDING and COPY.
REQ-017 SHALL, in PENDING, detect the vsync rising edge (registered vsync 0, current vsync 1) and enter COPY on the next cycle.
REQ-018 SHALL, in COPY, copy one slot per pixel_clk (index 0 to NUM_SPRITES-1) via counter copy_idx, then return to IDLE; COPY lasts exactly NUM_SPRITES cycles.
REQ-019 SHALL drive commit_pending=1 in PENDING and COPY, and 0 in IDLE.
REQ-020 SHALL ignore vsync edges in IDLE and COPY.
REQ-021 SHALL make pipeline stage 1 (on vtg_ce) register coordinates, next_video_on, hsync and vsync, and compute per-slot hit = enable && x<=px<x+SPRITE_SIZE && y<=py<y+SPRITE_SIZE.
REQ-022 SHALL do the hit comparisons at 11 bits so sprites at x or y >= 1024-SPRITE_SIZE clip and do not wrap.
REQ-023 SHALL make pipeline stage 2 (on vtg_ce) select the colour of the lowest-index hit slot, else BG_COLOR.
REQ-024 SHALL drive rgb = 12'h000 when the delayed video_on is 0, regardless of hits.
REQ-025 SHALL give rgb, de_out, hsync_out and vsync_out the same 2-enabled-cycle latency from the inputs, so they stay mutually aligned.
REQ-026 SHALL hold all pipeline registers when vtg_ce=0.
REQ-027 SHALL render from slots copied mid-frame in COPY starting with the next enabled cycle; COPY falls in vblank, so there is no visible tearing.

Reset
REQ-028 SHALL, while reset_n=0, put the FSM in IDLE, clear copy_idx, and clear enable in both tables (x, y and colour are don't-care).
REQ-029 SHALL, while reset_n=0, drive rgb=0, de_out=0, hsync_out=0, vsync_out=0, commit_pending=0 and spr_wr_ready=0.
REQ-030 SHALL raise spr_wr_ready on the first clock after reset_n deasserts.
REQ-031 SHALL, on reset in PENDING or COPY, abandon the commit and leave active-table slots disabled.

Structure
REQ-032 SHALL place sprite_attr_t {enable, x[9:0], y[9:0], color[11:0]}, the FSM state enum and NUM_SPRITES/SPRITE_SIZE defaults in starsoc_params.
REQ-033 SHALL use one sub-module, sprite_hit_cmp: combinational per-slot hit compare, instantiated NUM_SPRITES times.

Verification
REQ-034 SHALL cover: write slot 0 (x=100,y=50,F00,en), commit, vsync rise -> commit_pending low after exactly 8+1 cycles; pixel (100,50) rgb=F00 two enables later; (116,50) rgb=BG.
REQ-035 SHALL cover: slots 2 and 5 overlap at (200,200), colours 0F0/00F -> rgb=0F0.
REQ-036 SHALL cover: write slot 1 with no commit -> active unchanged, rgb=BG at its area across two frames.
REQ-037 SHALL cover: sprite at x=1020 -> pixels 1020..1023 hit, pixels 0..11 of the same line do not hit.
REQ-038 SHALL cover: vtg_ce toggling 1/0 -> outputs change only on enabled cycles; latency stays 2 enabled cycles.
REQ-039 SHALL cover: reset_n low during COPY at copy_idx=3 -> IDLE, all slots disabled, rgb=BG inside the visible area.

Source files
------------

// File: rtl/starsoc_params.sv
//------------------------------------------------------------------------------
// Module      : starsoc_params (package)
// Description : Shared types and defaults for the sprite compositor: sprite
//               attribute record, commit FSM state encoding and default sizes.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package starsoc_params;

    localparam int c_default_num_sprites = 8;
    localparam int c_default_sprite_size = 16;

    // One sprite slot: visibility flag, top-left corner and solid RGB444 colour.
    typedef struct packed {
        logic        enable;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [11:0] color;
    } sprite_attr_t;

    // Shadow-to-active commit sequencer.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_COPY    = 2'd2
    } commit_state_t;

endpackage

`default_nettype wire

// File: rtl/sprite_hit_cmp.sv
//------------------------------------------------------------------------------
// Module      : sprite_hit_cmp
// Description : Combinational test of whether a pixel lies inside one square
//               sprite.
//   i_enable      slot visible
//   i_x, i_y      sprite top-left corner
//   i_px, i_py    pixel coordinate under test
//   o_hit         pixel covered by this sprite
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sprite_hit_cmp
    import starsoc_params::*;
#(
    parameter int SPRITE_SIZE = c_default_sprite_size
) (
    input  logic       i_enable,
    input  logic [9:0] i_x,
    input  logic [9:0] i_y,
    input  logic [9:0] i_px,
    input  logic [9:0] i_py,
    output logic       o_hit
);

    // 11-bit arithmetic: a sprite near the right/bottom edge has its far edge
    // beyond 1023, so it is clipped instead of wrapping onto column/row 0.
    logic [10:0] w_px;
    logic [10:0] w_py;
    logic [10:0] w_x0;
    logic [10:0] w_y0;
    logic [10:0] w_x1;
    logic [10:0] w_y1;

    assign w_px = {1'b0, i_px};
    assign w_py = {1'b0, i_py};
    assign w_x0 = {1'b0, i_x};
    assign w_y0 = {1'b0, i_y};
    assign w_x1 = w_x0 + 11'(SPRITE_SIZE);
    assign w_y1 = w_y0 + 11'(SPRITE_SIZE);

    assign o_hit = i_enable
                 && (w_px >= w_x0) && (w_px < w_x1)
                 && (w_py >= w_y0) && (w_py < w_y1);

endmodule

`default_nettype wire

// File: rtl/sprite_compositor.sv
//------------------------------------------------------------------------------
// Module      : sprite_compositor
// Description : Overlays up to NUM_SPRITES solid square sprites onto a video
//               stream. The host edits a shadow table; a commit request copies
//               it into the active table during the next vertical sync so the
//               visible frame never tears.
//   pixel_clk / reset_n          pixel clock, async active-low reset
//   vtg_ce                       pixel enable for the render pipeline
//   next_pixel_x/y, next_video_on, hsync, vsync   timing generator inputs
//   spr_wr_*                     shadow-table write port (valid/ready)
//   commit_req / commit_pending  commit request pulse / commit in progress
//   rgb, de_out, hsync_out, vsync_out  pipelined video out (2 enabled cycles)
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sprite_compositor
    import starsoc_params::*;
#(
    parameter int          NUM_SPRITES = c_default_num_sprites,
    parameter int          SPRITE_SIZE = c_default_sprite_size,
    parameter logic [11:0] BG_COLOR    = 12'h000,
    localparam int         IDX_W       = $clog2(NUM_SPRITES)
) (
    input  logic             pixel_clk,
    input  logic             reset_n,
    input  logic             vtg_ce,
    input  logic [9:0]       next_pixel_x,
    input  logic [9:0]       next_pixel_y,
    input  logic             next_video_on,
    input  logic             hsync,
    input  logic             vsync,
    input  logic             spr_wr_valid,
    output logic             spr_wr_ready,
    input  logic [IDX_W-1:0] spr_wr_idx,
    input  logic [9:0]       spr_wr_x,
    input  logic [9:0]       spr_wr_y,
    input  logic [11:0]      spr_wr_color,
    input  logic             spr_wr_enable,
    input  logic             commit_req,
    output logic             commit_pending,
    output logic [11:0]      rgb,
    output logic             de_out,
    output logic             hsync_out,
    output logic             vsync_out
);

    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_SPRITES - 1);

    sprite_attr_t     r_shadow [NUM_SPRITES];
    sprite_attr_t     r_active [NUM_SPRITES];
    commit_state_t    r_state;
    commit_state_t    w_state_next;
    logic [IDX_W-1:0] r_copy_idx;
    logic             r_vsync_d;
    logic             r_ready_armed;
    logic             w_wr_accept;
    sprite_attr_t     w_wr_attr;

    // Write port is closed for the reset cycle and whenever a commit is in
    // flight, so the shadow table cannot change underneath the copy.
    assign spr_wr_ready   = r_ready_armed && (r_state == ST_IDLE);
    assign commit_pending = (r_state != ST_IDLE);
    assign w_wr_accept    = spr_wr_valid && spr_wr_ready;

    assign w_wr_attr.enable = spr_wr_enable;
    assign w_wr_attr.x      = spr_wr_x;
    assign w_wr_attr.y      = spr_wr_y;
    assign w_wr_attr.color  = spr_wr_color;

    //--------------------------------------------------------------------------
    // Commit FSM: runs every pixel_clk, independent of vtg_ce
    //--------------------------------------------------------------------------
    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_copy_idx    <= '0;
            r_vsync_d     <= 1'b0;
            r_ready_armed <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_vsync_d     <= vsync;
            r_ready_armed <= 1'b1;
            if (r_state == ST_COPY) begin
                r_copy_idx <= (r_copy_idx == c_last_idx) ? '0 : r_copy_idx + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (commit_req) begin
                    w_state_next = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (!r_vsync_d && vsync) begin
                    w_state_next = ST_COPY;
                end
            end
            ST_COPY: begin
                if (r_copy_idx == c_last_idx) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    //--------------------------------------------------------------------------
    // Sprite tables
    //--------------------------------------------------------------------------
    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                r_shadow[i] <= '0;
            end
        end else if (w_wr_accept) begin
            r_shadow[spr_wr_idx] <= w_wr_attr;
        end
    end

    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                r_active[i] <= '0;
            end
        end else if (r_state == ST_COPY) begin
            r_active[r_copy_idx] <= r_shadow[r_copy_idx];
        end
    end

    //--------------------------------------------------------------------------
    // Render pipeline: stage 1 registers the timing inputs, the hit compare
    // and priority select run on the stage-1 coordinates, stage 2 registers
    // the final pixel alongside the delayed sync/enable flags.
    //--------------------------------------------------------------------------
    logic [9:0]             r_px;
    logic [9:0]             r_py;
    logic                   r_video_on;
    logic                   r_hsync;
    logic                   r_vsync;
    logic [NUM_SPRITES-1:0] w_hit;
    logic [11:0]            w_pix_color;
    logic [11:0]            r_rgb;
    logic                   r_de;
    logic                   r_hsync_out;
    logic                   r_vsync_out;

    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_px       <= '0;
            r_py       <= '0;
            r_video_on <= 1'b0;
            r_hsync    <= 1'b0;
            r_vsync    <= 1'b0;
        end else if (vtg_ce) begin
            r_px       <= next_pixel_x;
            r_py       <= next_pixel_y;
            r_video_on <= next_video_on;
            r_hsync    <= hsync;
            r_vsync    <= vsync;
        end
    end

    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_hit
        sprite_hit_cmp #(
            .SPRITE_SIZE (SPRITE_SIZE)
        ) u_hit_cmp (
            .i_enable (r_active[g].enable),
            .i_x      (r_active[g].x),
            .i_y      (r_active[g].y),
            .i_px     (r_px),
            .i_py     (r_py),
            .o_hit    (w_hit[g])
        );
    end

    // Walk from the highest index down so the lowest-index hit wins.
    always_comb begin
        w_pix_color = BG_COLOR;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_pix_color = r_active[i].color;
            end
        end
    end

    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rgb       <= 12'h000;
            r_de        <= 1'b0;
            r_hsync_out <= 1'b0;
            r_vsync_out <= 1'b0;
        end else if (vtg_ce) begin
            r_rgb       <= r_video_on ? w_pix_color : 12'h000;
            r_de        <= r_video_on;
            r_hsync_out <= r_hsync;
            r_vsync_out <= r_vsync;
        end
    end

    assign rgb       = r_rgb;
    assign de_out    = r_de;
    assign hsync_out = r_hsync_out;
    assign vsync_out = r_vsync_out;

endmodule

`default_nettype wire

// File: tb/tb_sprite_compositor.sv
//------------------------------------------------------------------------------
// Module      : tb_sprite_compositor
// Description : Self-checking bench for sprite_compositor. Pixel vectors come
//               from small tables; each driven pixel pushes its expected
//               output to a scoreboard that is popped two enabled cycles later.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sprite_compositor;
    import starsoc_params::*;

    localparam logic [11:0] c_bg = 12'h135;

    logic        pixel_clk;
    logic        reset_n;
    logic        vtg_ce;
    logic [9:0]  next_pixel_x;
    logic [9:0]  next_pixel_y;
    logic        next_video_on;
    logic        hsync;
    logic        vsync;
    logic        spr_wr_valid;
    logic        spr_wr_ready;
    logic [2:0]  spr_wr_idx;
    logic [9:0]  spr_wr_x;
    logic [9:0]  spr_wr_y;
    logic [11:0] spr_wr_color;
    logic        spr_wr_enable;
    logic        commit_req;
    logic        commit_pending;
    logic [11:0] rgb;
    logic        de_out;
    logic        hsync_out;
    logic        vsync_out;

    sprite_compositor #(
        .NUM_SPRITES (8),
        .SPRITE_SIZE (16),
        .BG_COLOR    (c_bg)
    ) dut (
        .pixel_clk      (pixel_clk),
        .reset_n        (reset_n),
        .vtg_ce         (vtg_ce),
        .next_pixel_x   (next_pixel_x),
        .next_pixel_y   (next_pixel_y),
        .next_video_on  (next_video_on),
        .hsync          (hsync),
        .vsync          (vsync),
        .spr_wr_valid   (spr_wr_valid),
        .spr_wr_ready   (spr_wr_ready),
        .spr_wr_idx     (spr_wr_idx),
        .spr_wr_x       (spr_wr_x),
        .spr_wr_y       (spr_wr_y),
        .spr_wr_color   (spr_wr_color),
        .spr_wr_enable  (spr_wr_enable),
        .commit_req     (commit_req),
        .commit_pending (commit_pending),
        .rgb            (rgb),
        .de_out         (de_out),
        .hsync_out      (hsync_out),
        .vsync_out      (vsync_out)
    );

    initial begin
        pixel_clk = 1'b0;
        forever #20 pixel_clk = ~pixel_clk;
    end

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        von;
        logic        hs;
        logic        vs;
        logic [11:0] rgb;
    } vec_t;

    typedef struct packed {
        logic [11:0] rgb;
        logic        de;
        logic        hs;
        logic        vs;
    } exp_t;

    vec_t tbl[$];
    exp_t sb_q[$];
    exp_t sb_e;
    exp_t last_exp;
    int   inflight;
    int   n_checks;
    int   n_errors;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void add(input logic [9:0] x, input logic [9:0] y, input logic von,
                                input logic hs, input logic vs, input logic [11:0] c);
        vec_t v;
        v.x = x; v.y = y; v.von = von; v.hs = hs; v.vs = vs; v.rgb = c;
        tbl.push_back(v);
    endfunction

    // One enabled pixel; its expectation enters the scoreboard as it is driven.
    task automatic pix(input vec_t v);
        exp_t e;
        @(negedge pixel_clk);
        next_pixel_x  = v.x;
        next_pixel_y  = v.y;
        next_video_on = v.von;
        hsync         = v.hs;
        vsync         = v.vs;
        vtg_ce        = 1'b1;
        e.rgb = v.von ? v.rgb : 12'h000;
        e.de  = v.von;
        e.hs  = v.hs;
        e.vs  = v.vs;
        sb_q.push_back(e);
        @(posedge pixel_clk);
        #2 vtg_ce = 1'b0;
    endtask

    task automatic run_tbl();
        foreach (tbl[i]) pix(tbl[i]);
        tbl.delete();
    endtask

    task automatic flush_pix();
        add(10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 12'h000);
        run_tbl();
    endtask

    // Disabled cycle with changing inputs: outputs must keep the last result.
    task automatic ce_off(input string name);
        @(negedge pixel_clk);
        vtg_ce        = 1'b0;
        next_pixel_x  = 10'd1021;
        next_pixel_y  = 10'd400;
        next_video_on = 1'b1;
        hsync         = ~hsync;
        @(posedge pixel_clk);
        #1;
        chk(name, {17'd0, rgb, de_out, hsync_out, vsync_out}, {17'd0, last_exp});
    endtask

    task automatic write_slot(input logic [2:0] idx, input logic [9:0] x, input logic [9:0] y,
                              input logic [11:0] c, input logic en);
        int waited;
        waited = 0;
        @(negedge pixel_clk);
        spr_wr_valid  = 1'b1;
        spr_wr_idx    = idx;
        spr_wr_x      = x;
        spr_wr_y      = y;
        spr_wr_color  = c;
        spr_wr_enable = en;
        while (!spr_wr_ready && waited < 20) begin
            @(negedge pixel_clk);
            waited++;
        end
        chk("wr_ready", 32'(spr_wr_ready), 32'd1);
        @(posedge pixel_clk);
        #2 spr_wr_valid = 1'b0;
    endtask

    task automatic do_commit(input int exp_cycles);
        int n;
        bit done;
        flush_pix();
        @(negedge pixel_clk);
        commit_req = 1'b1;
        @(negedge pixel_clk);
        commit_req = 1'b0;
        chk("commit_pending_set", 32'(commit_pending), 32'd1);
        vsync = 1'b1;
        n = 0;
        done = 1'b0;
        while (!done && n < 40) begin
            @(posedge pixel_clk);
            #1;
            n++;
            if (!commit_pending) done = 1'b1;
        end
        chk("commit_cycles", 32'(n), 32'(exp_cycles));
        @(negedge pixel_clk);
        vsync = 1'b0;
    endtask

    // Scoreboard consumer: on each enabled edge the pixel held in stage 1
    // reaches the outputs.
    always @(posedge pixel_clk) begin
        if (reset_n && vtg_ce) begin
            if (inflight == 1) begin
                #1;
                if (sb_q.size() == 0) begin
                    chk("sb_underflow", 32'(sb_q.size()), 32'd1);
                end else begin
                    sb_e = sb_q.pop_front();
                    chk("pipe_rgb", 32'(rgb), 32'(sb_e.rgb));
                    chk("pipe_sync", {29'd0, de_out, hsync_out, vsync_out},
                        {29'd0, sb_e.de, sb_e.hs, sb_e.vs});
                    last_exp = sb_e;
                end
            end
            inflight = 1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0; n_errors = 0; inflight = 0; last_exp = '0;
        reset_n = 1'b0; vtg_ce = 1'b0;
        next_pixel_x = 10'd100; next_pixel_y = 10'd50; next_video_on = 1'b1;
        hsync = 1'b1; vsync = 1'b1;
        spr_wr_valid = 1'b0; spr_wr_idx = '0; spr_wr_x = '0; spr_wr_y = '0;
        spr_wr_color = '0; spr_wr_enable = 1'b0; commit_req = 1'b0;

        // Reset state
        #90;
        chk("rst_rgb", 32'(rgb), 32'd0);
        chk("rst_flags", {29'd0, de_out, hsync_out, vsync_out}, 32'd0);
        chk("rst_pending", 32'(commit_pending), 32'd0);
        chk("rst_ready", 32'(spr_wr_ready), 32'd0);
        @(negedge pixel_clk);
        hsync = 1'b0; vsync = 1'b0; next_video_on = 1'b0;
        reset_n = 1'b1;
        chk("ready_before_clk", 32'(spr_wr_ready), 32'd0);
        @(posedge pixel_clk);
        #1 chk("ready_after_clk", 32'(spr_wr_ready), 32'd1);

        // Single sprite, commit timing, edges of the square
        write_slot(3'd0, 10'd100, 10'd50, 12'hF00, 1'b1);
        do_commit(9);
        add(10'd100, 10'd50, 1'b1, 1'b0, 1'b0, 12'hF00);
        add(10'd116, 10'd50, 1'b1, 1'b1, 1'b0, c_bg);
        add(10'd115, 10'd65, 1'b1, 1'b0, 1'b0, 12'hF00);
        add(10'd99,  10'd50, 1'b1, 1'b0, 1'b0, c_bg);
        add(10'd100, 10'd66, 1'b1, 1'b0, 1'b1, c_bg);
        add(10'd100, 10'd50, 1'b0, 1'b1, 1'b1, 12'h000);
        run_tbl();

        // Overlap priority: slot 2 beats slot 5
        write_slot(3'd2, 10'd192, 10'd192, 12'h0F0, 1'b1);
        write_slot(3'd5, 10'd200, 10'd200, 12'h00F, 1'b1);
        do_commit(9);
        add(10'd200, 10'd200, 1'b1, 1'b0, 1'b0, 12'h0F0);
        add(10'd207, 10'd207, 1'b1, 1'b0, 1'b0, 12'h0F0);
        add(10'd208, 10'd208, 1'b1, 1'b0, 1'b0, 12'h00F);
        add(10'd215, 10'd215, 1'b1, 1'b0, 1'b0, 12'h00F);
        add(10'd216, 10'd216, 1'b1, 1'b0, 1'b0, c_bg);
        add(10'd199, 10'd199, 1'b1, 1'b0, 1'b0, 12'h0F0);
        run_tbl();

        // Shadow write without commit stays invisible over two frames
        write_slot(3'd1, 10'd300, 10'd300, 12'hFFF, 1'b1);
        add(10'd300, 10'd300, 1'b1, 1'b0, 1'b0, c_bg);
        add(10'd315, 10'd315, 1'b1, 1'b0, 1'b0, c_bg);
        add(10'd0,   10'd0,   1'b0, 1'b0, 1'b1, 12'h000);
        add(10'd0,   10'd0,   1'b0, 1'b0, 1'b0, 12'h000);
        run_tbl();
        chk("no_commit_pending", 32'(commit_pending), 32'd0);
        add(10'd300, 10'd300, 1'b1, 1'b0, 1'b0, c_bg);
        add(10'd310, 10'd305, 1'b1, 1'b0, 1'b0, c_bg);
        run_tbl();

        // Right-edge clipping
        write_slot(3'd1, 10'd1020, 10'd400, 12'hABC, 1'b1);
        do_commit(9);
        add(10'd1019, 10'd400, 1'b1, 1'b0, 1'b0, c_bg);
        add(10'd1020, 10'd400, 1'b1, 1'b0, 1'b0, 12'hABC);
        add(10'd1021, 10'd400, 1'b1, 1'b0, 1'b0, 12'hABC);
        add(10'd1023, 10'd400, 1'b1, 1'b0, 1'b0, 12'hABC);
        add(10'd0,    10'd400, 1'b1, 1'b0, 1'b0, c_bg);
        add(10'd5,    10'd400, 1'b1, 1'b0, 1'b0, c_bg);
        add(10'd11,   10'd400, 1'b1, 1'b0, 1'b0, c_bg);
        add(10'd1022, 10'd415, 1'b1, 1'b0, 1'b0, 12'hABC);
        add(10'd1022, 10'd416, 1'b1, 1'b0, 1'b0, c_bg);
        run_tbl();

        // vtg_ce toggling: hold on disabled cycles, latency in enabled cycles
        add(10'd100, 10'd50, 1'b1, 1'b1, 1'b0, 12'hF00);
        run_tbl();
        ce_off("hold_a");
        add(10'd116, 10'd50, 1'b1, 1'b0, 1'b0, c_bg);
        run_tbl();
        ce_off("hold_b");
        ce_off("hold_c");
        add(10'd200, 10'd200, 1'b1, 1'b1, 1'b0, 12'h0F0);
        run_tbl();
        ce_off("hold_d");
        add(10'd1021, 10'd400, 1'b1, 1'b0, 1'b0, 12'hABC);
        run_tbl();
        ce_off("hold_e");

        // Reset in the middle of a copy (copy_idx = 3)
        flush_pix();
        @(negedge pixel_clk);
        commit_req = 1'b1;
        @(negedge pixel_clk);
        commit_req = 1'b0;
        vsync = 1'b1;
        repeat (4) @(posedge pixel_clk);
        #1 chk("copy_in_progress", 32'(commit_pending), 32'd1);
        reset_n = 1'b0;
        sb_q.delete();
        inflight = 0;
        #1;
        chk("midcopy_rst_pending", 32'(commit_pending), 32'd0);
        chk("midcopy_rst_ready", 32'(spr_wr_ready), 32'd0);
        chk("midcopy_rst_rgb", 32'(rgb), 32'd0);
        @(negedge pixel_clk);
        vsync = 1'b0;
        repeat (2) @(negedge pixel_clk);
        reset_n = 1'b1;
        @(posedge pixel_clk);
        #1 chk("midcopy_ready", 32'(spr_wr_ready), 32'd1);
        add(10'd100,  10'd50,  1'b1, 1'b0, 1'b0, c_bg);
        add(10'd200,  10'd200, 1'b1, 1'b0, 1'b0, c_bg);
        add(10'd1021, 10'd400, 1'b1, 1'b0, 1'b0, c_bg);
        add(10'd101,  10'd51,  1'b0, 1'b0, 1'b1, 12'h000);
        add(10'd0,    10'd0,   1'b0, 1'b0, 1'b0, 12'h000);
        run_tbl();
        chk("idle_vsync_ignored", 32'(commit_pending), 32'd0);
        flush_pix();
        chk("sb_in_flight", 32'(sb_q.size()), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
